// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage MD issue/hazard control with a shadow busy countdown; `MDU_PERF_CNT_EN adds perf_issue/perf_stall counters.
module mdu_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_md_sel,
  input  logic       d_md_use,
  input  logic       mdu_busy,
  output logic       mdu_start,
  output logic [3:0] mdu_op,
  output logic [3:0] mdu_time,
  output logic [1:0] read_hilo,
  output logic       stall_d,
  output logic       busy_err
`ifdef MDU_PERF_CNT_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
`endif
);
  localparam logic [3:0] MT = 4'(MULT_CYCLES);
  localparam logic [3:0] DT = 4'(DIV_CYCLES);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic mult, div, seq, mv, shadow;
  always_comb begin
    mult = e_md_sel inside {4'b0001, 4'b0010};
    div = e_md_sel inside {4'b0011, 4'b0100, 4'b1000};
    seq = mult || div;
    mv = e_md_sel inside {4'b0101, 4'b0110};
    shadow = state == BUSY;
    mdu_start = e_valid && seq && !shadow;
    mdu_op = e_valid && (seq || mv) ? e_md_sel : 4'b0000;
    mdu_time = !e_valid ? 4'd0 : mult ? MT : div ? DT : 4'd0;
    read_hilo = !e_valid ? 2'b00 : e_md_sel == 4'b1001 ? 2'b10 : e_md_sel == 4'b1010 ? 2'b01 : 2'b00;
    stall_d = d_md_use && (mdu_start || shadow || mdu_busy);
  end
  // the unit's busy flag includes the start cycle, so disagreement is only judged when not starting
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      busy_err <= 1'b0;
    end else begin
      busy_err <= busy_err || (e_valid && seq && shadow) || (mdu_busy != shadow && !mdu_start);
      if (mdu_start) begin
        state <= BUSY;
        cnt <= mdu_time;
      end else if (shadow) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end
    end
  end
`ifdef MDU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      perf_issue <= perf_issue + 32'(mdu_start);
      perf_stall <= perf_stall + 32'(stall_d);
    end
  end
`endif
endmodule
